// File: rtl/apm_meas_ctrl_if.sv
// Valid/ready result channel between apm_meas_ctrl (master) and the
// telemetry register block (slave).
interface apm_meas_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;
  logic [3:0]       res_vdac;
  logic             res_last;

  modport master (
    output res_valid,
    output res_count,
    output res_ovf,
    output res_vdac,
    output res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_count,
    input  res_ovf,
    input  res_vdac,
    input  res_last,
    output res_ready
  );
endinterface

// File: rtl/apm_meas_ctrl.sv
// APM measurement controller: settles the sensor, counts oscillator edges over a
// fixed window and hands the count upstream. `APM_MEAS_CTRL_SWEEP_EN adds a VDAC sweep.
module apm_meas_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_cal,
  input  logic                   cfg_step,
  input  logic                   cfg_osc_sel,
  input  logic [1:0]             cfg_xtor_sel,
  input  logic [3:0]             cfg_mux_sel,
  input  logic [3:0]             cfg_vdac_sel,
  output logic                   busy,
  apm_meas_ctrl_if.master        res,
  output logic                   apm_en_sensor,
  output logic                   apm_en_osc,
  output logic                   apm_en_cal,
  output logic                   apm_en_step,
  output logic                   apm_osc_sel,
  output logic [1:0]             apm_xtor_sel,
  output logic [3:0]             apm_mux_sel,
  output logic [3:0]             apm_vdac_sel,
  input  logic                   apm_osc_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    MEAS   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int MAX_CYC = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  localparam logic [CYC_W-1:0] SETTLE_END = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WIN_END    = CYC_W'(WIN_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE    = CNT_SAT - CNT_ONE;

  state_t           state;
  state_t           state_next;
  logic             armed;
  logic [CYC_W-1:0] cyc;
  logic             cal_q;
  logic             step_q;
  logic             osc_sel_q;
  logic [1:0]       xtor_q;
  logic [3:0]       mux_q;
  logic [3:0]       vdac_q;
  logic             osc_meta;
  logic             osc_sync;
  logic             osc_prev;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic accept;
  logic osc_rise;
  logic settle_done;
  logic win_done;
  logic last_code;

  // A request is taken one cycle before SETTLE so the cfg registers are
  // already stable on the APM selects when the sensor enable rises.
  assign accept      = (state == IDLE) && !armed && start && !abort;
  assign osc_rise    = osc_sync && !osc_prev;
  assign settle_done = (cyc == SETTLE_END);
  assign win_done    = (cyc == WIN_END);
  assign last_code   = (vdac_q == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            state_next = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) begin
            state_next = MEAS;
          end
        end
        MEAS: begin
          if (win_done) begin
            state_next = REPORT;
          end
        end
        REPORT: begin
          if (res.res_ready) begin
`ifdef APM_MEAS_CTRL_SWEEP_EN
            state_next = last_code ? IDLE : SETTLE;
`else
            state_next = IDLE;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    apm_en_sensor = 1'b0;
    apm_en_osc    = 1'b0;
    apm_en_cal    = 1'b0;
    apm_en_step   = 1'b0;
    res.res_valid = 1'b0;
    case (state)
      SETTLE: begin
        apm_en_sensor = 1'b1;
        apm_en_cal    = cal_q;
        apm_en_step   = step_q;
      end
      MEAS: begin
        apm_en_sensor = 1'b1;
        apm_en_osc    = 1'b1;
        apm_en_cal    = cal_q;
        apm_en_step   = step_q;
      end
      REPORT: begin
        apm_en_sensor = 1'b1;
        apm_en_cal    = cal_q;
        apm_en_step   = step_q;
        res.res_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
`ifdef APM_MEAS_CTRL_SWEEP_EN
    res.res_last = res.res_valid && last_code;
`else
    res.res_last = res.res_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      armed     <= 1'b0;
      cyc       <= '0;
      cal_q     <= 1'b0;
      step_q    <= 1'b0;
      osc_sel_q <= 1'b0;
      xtor_q    <= '0;
      mux_q     <= '0;
      vdac_q    <= '0;
    end else begin
      armed <= accept;
      if (accept) begin
        cal_q     <= cfg_cal;
        step_q    <= cfg_step;
        osc_sel_q <= cfg_osc_sel;
        xtor_q    <= cfg_xtor_sel;
        mux_q     <= cfg_mux_sel;
        vdac_q    <= cfg_vdac_sel;
      end
`ifdef APM_MEAS_CTRL_SWEEP_EN
      if ((state == REPORT) && (state_next == SETTLE)) begin
        vdac_q <= vdac_q + 4'd1;
      end
`endif
      if (state_next != state) begin
        cyc <= '0;
      end else if ((state == SETTLE) || (state == MEAS)) begin
        cyc <= cyc + CYC_ONE;
      end
    end
  end

  // The oscillator is asynchronous; only the synchronized copy is edge-detected,
  // so edges still in flight when the window closes are simply lost.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      osc_meta <= 1'b0;
      osc_sync <= 1'b0;
      osc_prev <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      osc_meta <= apm_osc_out;
      osc_sync <= osc_meta;
      osc_prev <= osc_sync;
      if ((state != MEAS) && (state_next == MEAS)) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if ((state == MEAS) && osc_rise) begin
        if (count != CNT_SAT) begin
          count <= count + CNT_ONE;
        end
        if (count >= CNT_PRE) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign apm_osc_sel   = osc_sel_q;
  assign apm_xtor_sel  = xtor_q;
  assign apm_mux_sel   = mux_q;
  assign apm_vdac_sel  = vdac_q;
  assign res.res_count = count;
  assign res.res_ovf   = ovf;
  assign res.res_vdac  = vdac_q;

endmodule

// File: tb/tb_apm_meas_ctrl.sv
// Directed bench for apm_meas_ctrl: a 16-bit and a 4-bit counter instance share
// stimulus; expected results are queued at start and popped when res_valid appears.
module tb_apm_meas_ctrl;

  localparam int SETTLE = 4;
  localparam int WIN    = 100;

  typedef struct {
    int         lo;
    int         hi;
    logic       ovf;
    logic [3:0] vdac;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cfg_cal = 1'b0;
  logic       cfg_step = 1'b0;
  logic       cfg_osc_sel = 1'b0;
  logic [1:0] cfg_xtor_sel = 2'd0;
  logic [3:0] cfg_mux_sel = 4'd0;
  logic [3:0] cfg_vdac_sel = 4'd0;
  logic       res_ready = 1'b0;
  logic       osc = 1'b0;
  int         osc_half = 0;

  int checks = 0;
  int errors = 0;
  exp_t sb_wide[$];
  exp_t sb_narrow[$];

  logic       w_busy, w_en_sensor, w_en_osc, w_en_cal, w_en_step, w_osc_sel;
  logic [1:0] w_xtor;
  logic [3:0] w_mux, w_vdac;
  logic       n_busy, n_en_sensor, n_en_osc, n_en_cal, n_en_step, n_osc_sel;
  logic [1:0] n_xtor;
  logic [3:0] n_mux, n_vdac;

  apm_meas_ctrl_if #(.CNT_W(16)) wide_if ();
  apm_meas_ctrl_if #(.CNT_W(4))  narrow_if ();

  assign wide_if.res_ready   = res_ready;
  assign narrow_if.res_ready = res_ready;

  apm_meas_ctrl #(.SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .cfg_cal(cfg_cal), .cfg_step(cfg_step), .cfg_osc_sel(cfg_osc_sel),
    .cfg_xtor_sel(cfg_xtor_sel), .cfg_mux_sel(cfg_mux_sel), .cfg_vdac_sel(cfg_vdac_sel),
    .busy(w_busy), .res(wide_if.master),
    .apm_en_sensor(w_en_sensor), .apm_en_osc(w_en_osc), .apm_en_cal(w_en_cal),
    .apm_en_step(w_en_step), .apm_osc_sel(w_osc_sel), .apm_xtor_sel(w_xtor),
    .apm_mux_sel(w_mux), .apm_vdac_sel(w_vdac), .apm_osc_out(osc)
  );

  apm_meas_ctrl #(.SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .CNT_W(4)) dut_narrow (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .cfg_cal(cfg_cal), .cfg_step(cfg_step), .cfg_osc_sel(cfg_osc_sel),
    .cfg_xtor_sel(cfg_xtor_sel), .cfg_mux_sel(cfg_mux_sel), .cfg_vdac_sel(cfg_vdac_sel),
    .busy(n_busy), .res(narrow_if.master),
    .apm_en_sensor(n_en_sensor), .apm_en_osc(n_en_osc), .apm_en_cal(n_en_cal),
    .apm_en_step(n_en_step), .apm_osc_sel(n_osc_sel), .apm_xtor_sel(n_xtor),
    .apm_mux_sel(n_mux), .apm_vdac_sel(n_vdac), .apm_osc_out(osc)
  );

  always #5 clk = ~clk;

  // Oscillator toggles sit 3 time units off the clock grid so they never race an edge.
  always begin
    if (osc_half == 0) begin
      osc = 1'b0;
      @(osc_half);
      #3;
    end else begin
      #(osc_half) osc = ~osc;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic exp_t satModel(input int lo, input int hi, input int cnt_w,
                                    input logic [3:0] vdac, input logic last);
    exp_t e;
    int sat;
    sat    = (1 << cnt_w) - 1;
    e.lo   = (lo < sat) ? lo : sat;
    e.hi   = (hi < sat) ? hi : sat;
    e.ovf  = (lo >= sat);
    e.vdac = vdac;
    e.last = last;
    return e;
  endfunction

  task automatic expectResult(input int lo, input int hi, input logic [3:0] vdac, input logic last);
    sb_wide.push_back(satModel(lo, hi, 16, vdac, last));
    sb_narrow.push_back(satModel(lo, hi, 4, vdac, last));
  endtask

  // Caller sits at a negedge; start is sampled at the next posedge (edge 0)
  // and the task returns at the negedge following edge 0.
  task automatic applyStimulus(input logic cal, input logic step, input logic osel,
                               input logic [1:0] xtor, input logic [3:0] mux,
                               input logic [3:0] vdac);
    cfg_cal      = cal;
    cfg_step     = step;
    cfg_osc_sel  = osel;
    cfg_xtor_sel = xtor;
    cfg_mux_sel  = mux;
    cfg_vdac_sel = vdac;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!wide_if.res_valid && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_in_time"}, 32'(wide_if.res_valid), 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t ew;
    exp_t en;
    check({tag, "_sb_pending"}, 32'((sb_wide.size() != 0) && (sb_narrow.size() != 0)), 32'd1);
    if ((sb_wide.size() != 0) && (sb_narrow.size() != 0)) begin
      ew = sb_wide.pop_front();
      en = sb_narrow.pop_front();
      check({tag, "_valid_w"}, 32'(wide_if.res_valid), 32'd1);
      checkRange({tag, "_count_w"}, int'(wide_if.res_count), ew.lo, ew.hi);
      check({tag, "_ovf_w"}, 32'(wide_if.res_ovf), 32'(ew.ovf));
      check({tag, "_vdac_w"}, 32'(wide_if.res_vdac), 32'(ew.vdac));
      check({tag, "_last_w"}, 32'(wide_if.res_last), 32'(ew.last));
      check({tag, "_valid_n"}, 32'(narrow_if.res_valid), 32'd1);
      checkRange({tag, "_count_n"}, int'(narrow_if.res_count), en.lo, en.hi);
      check({tag, "_ovf_n"}, 32'(narrow_if.res_ovf), 32'(en.ovf));
      check({tag, "_vdac_n"}, 32'(narrow_if.res_vdac), 32'(en.vdac));
      check({tag, "_last_n"}, 32'(narrow_if.res_last), 32'(en.last));
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, 32'(w_busy), 32'd0);
    check({tag, "_en_sensor"}, 32'(w_en_sensor), 32'd0);
    check({tag, "_en_osc"}, 32'(w_en_osc), 32'd0);
    check({tag, "_en_cal"}, 32'(w_en_cal), 32'd0);
    check({tag, "_en_step"}, 32'(w_en_step), 32'd0);
    check({tag, "_osc_sel"}, 32'(w_osc_sel), 32'd0);
    check({tag, "_xtor"}, 32'(w_xtor), 32'd0);
    check({tag, "_mux"}, 32'(w_mux), 32'd0);
    check({tag, "_vdac"}, 32'(w_vdac), 32'd0);
    check({tag, "_res_valid"}, 32'(wide_if.res_valid), 32'd0);
    check({tag, "_res_count"}, 32'(wide_if.res_count), 32'd0);
    check({tag, "_res_ovf"}, 32'(wide_if.res_ovf), 32'd0);
    check({tag, "_res_vdac"}, 32'(wide_if.res_vdac), 32'd0);
    check({tag, "_res_last"}, 32'(wide_if.res_last), 32'd0);
    check({tag, "_busy_n"}, 32'(n_busy), 32'd0);
  endtask

  task automatic watchQuiet(input string tag, input int cycles);
    logic saw_valid;
    logic saw_busy;
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      saw_valid = saw_valid | wide_if.res_valid | narrow_if.res_valid;
      saw_busy  = saw_busy | w_busy;
    end
    check({tag, "_no_result"}, 32'(saw_valid), 32'd0);
    check({tag, "_no_busy"}, 32'(saw_busy), 32'd0);
  endtask

  initial begin
    logic [15:0] snap;
    $display("[TB] reset");
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_b = 1'b1;
    @(negedge clk);

    $display("[TB] timing and clk/8 measurement");
    osc_half = 40;
    repeat (10) @(negedge clk);
    expectResult(12, 13, 4'hF, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 4'd5, 4'hF);
    check("a_busy_e0", 32'(w_busy), 32'd0);
    for (int e = 1; e <= SETTLE + WIN + 1; e++) begin
      @(negedge clk);
      if (e == 1) begin
        check("a_busy_e1", 32'(w_busy), 32'd1);
        check("a_sensor_e1", 32'(w_en_sensor), 32'd1);
        check("a_osc_e1", 32'(w_en_osc), 32'd0);
        check("a_cal_e1", 32'(w_en_cal), 32'd1);
        check("a_step_e1", 32'(w_en_step), 32'd0);
        check("a_oscsel_e1", 32'(w_osc_sel), 32'd1);
        check("a_xtor_e1", 32'(w_xtor), 32'd2);
        check("a_mux_e1", 32'(w_mux), 32'd5);
        check("a_vdac_e1", 32'(w_vdac), 32'd15);
      end
      if (e == SETTLE) check("a_osc_settle_end", 32'(w_en_osc), 32'd0);
      if (e == SETTLE + 1) check("a_osc_rise", 32'(w_en_osc), 32'd1);
      if (e == SETTLE + WIN) begin
        check("a_osc_win_end", 32'(w_en_osc), 32'd1);
        check("a_valid_early", 32'(wide_if.res_valid), 32'd0);
      end
    end
    check("a_valid_rise", 32'(wide_if.res_valid), 32'd1);
    check("a_osc_fall", 32'(w_en_osc), 32'd0);
    check("a_sensor_report", 32'(w_en_sensor), 32'd1);

    snap = wide_if.res_count;
    for (int i = 0; i < 10; i++) begin
      start        = i[0];
      cfg_vdac_sel = 4'd3;
      cfg_mux_sel  = 4'd12;
      @(negedge clk);
      check("a_hold_valid", 32'(wide_if.res_valid), 32'd1);
      check("a_hold_count", 32'(wide_if.res_count), 32'(snap));
      check("a_hold_vdac", 32'(wide_if.res_vdac), 32'd15);
      check("a_hold_mux", 32'(w_mux), 32'd5);
    end
    start = 1'b0;
    checkOutput("a");
    res_ready = 1'b1;
    @(negedge clk);
    check("a_consumed_valid", 32'(wide_if.res_valid), 32'd0);
    check("a_consumed_busy", 32'(w_busy), 32'd0);
    check("a_consumed_sensor", 32'(w_en_sensor), 32'd0);
    repeat (3) @(negedge clk);
    check("a_start_ignored", 32'(w_busy), 32'd0);

    $display("[TB] clk/4 saturation and back-to-back start");
    osc_half = 20;
    repeat (10) @(negedge clk);
    expectResult(24, 26, 4'hF, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 4'd10, 4'hF);
    waitValid("b", SETTLE + WIN + 20);
    checkOutput("b");
    @(negedge clk);
    check("b_idle_valid", 32'(wide_if.res_valid), 32'd0);
    check("b_idle_busy", 32'(w_busy), 32'd0);

    $display("[TB] abort during settle");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 4'd6, 4'hF);
    @(negedge clk);
    check("c_b2b_busy", 32'(w_busy), 32'd1);
    check("c_step_settle", 32'(w_en_step), 32'd1);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("c_abort_busy", 32'(w_busy), 32'd0);
    check("c_abort_sensor", 32'(w_en_sensor), 32'd0);
    check("c_abort_osc", 32'(w_en_osc), 32'd0);
    check("c_abort_cal", 32'(w_en_cal), 32'd0);
    check("c_abort_step", 32'(w_en_step), 32'd0);
    watchQuiet("c", SETTLE + WIN + 20);

    $display("[TB] vdac start code 13");
    osc_half = 40;
    repeat (10) @(negedge clk);
`ifdef APM_MEAS_CTRL_SWEEP_EN
    expectResult(12, 13, 4'd13, 1'b0);
    expectResult(12, 13, 4'd14, 1'b0);
    expectResult(12, 13, 4'd15, 1'b1);
`else
    expectResult(12, 13, 4'd13, 1'b1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 4'd2, 4'd13);
    for (int k = 0; (k < 4) && (sb_wide.size() != 0); k++) begin
      waitValid("d", SETTLE + WIN + 20);
      checkOutput("d");
      @(negedge clk);
    end
    check("d_done_busy", 32'(w_busy), 32'd0);
    watchQuiet("d_after", SETTLE + WIN + 20);

    $display("[TB] reset mid-measurement");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 4'd9, 4'd7);
    repeat (30) @(negedge clk);
    check("e_in_meas", 32'(w_en_osc), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    checkAllZero("e");
    rst_b = 1'b1;
    watchQuiet("e_after", SETTLE + WIN + 40);

    check("sb_drained", 32'(sb_wide.size() + sb_narrow.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
